// File: rtl/wb_port_arbiter.sv
// Round-robin arbiter sharing two regfile write ports among four execute-side stages.
// Latency: req_ready combinational same cycle; granted result registered, visible on wbN the next cycle.
// Backpressure: wb requesters beyond the first two in scan order see req_ready=0 and must hold; flush drops all.
//
// Ports:
//   clock, reset_n       - clock, asynchronous active-low reset
//   flush_valid          - pipeline flush: blocks all grants, clears write enables and pointer next edge
//   req_valid/need_to_wb - per-requester valid and "writes a destination" flags (bit i = requester i)
//   req_prd/req_data     - per-requester destination preg and result, slice i = requester i
//   req_ready            - per-requester accept (combinational)
//   wb0_*/wb1_*          - registered write ports; port 1 is only used alongside port 0
//   rr_ptr_o             - current round-robin pointer
module wb_port_arbiter #(
    parameter int PREG_W = 6,
    parameter int DATA_W = 64,
    parameter int NREQ   = 4
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     flush_valid,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ-1:0]          req_need_to_wb,
    input  logic [NREQ*PREG_W-1:0]   req_prd,
    input  logic [NREQ*DATA_W-1:0]   req_data,
    output logic [NREQ-1:0]          req_ready,
    output logic                     wb0_valid,
    output logic [PREG_W-1:0]        wb0_prd,
    output logic [DATA_W-1:0]        wb0_data,
    output logic                     wb1_valid,
    output logic [PREG_W-1:0]        wb1_prd,
    output logic [DATA_W-1:0]        wb1_data,
    output logic [1:0]               rr_ptr_o
);

    logic              wb0_valid_q, wb0_valid_d;
    logic              wb1_valid_q, wb1_valid_d;
    logic [PREG_W-1:0] wb0_prd_q, wb0_prd_d;
    logic [PREG_W-1:0] wb1_prd_q, wb1_prd_d;
    logic [DATA_W-1:0] wb0_data_q, wb0_data_d;
    logic [DATA_W-1:0] wb1_data_q, wb1_data_d;
    logic [1:0]        rr_ptr_q, rr_ptr_d;

    // Arbitration results: first/second wb requester found in scan order.
    logic              grant0, grant1;
    logic [1:0]        g0_idx, g1_idx;
    logic [1:0]        scan_idx;

    always_comb begin
        grant0   = 1'b0;
        grant1   = 1'b0;
        g0_idx   = 2'd0;
        g1_idx   = 2'd0;
        scan_idx = 2'd0;
        // Two-bit addition wraps naturally, giving the mod-4 scan order.
        for (int k = 0; k < NREQ; k++) begin
            scan_idx = rr_ptr_q + 2'(k);
            if (req_valid[scan_idx] && req_need_to_wb[scan_idx]) begin
                if (!grant0) begin
                    grant0 = 1'b1;
                    g0_idx = scan_idx;
                end else if (!grant1) begin
                    grant1 = 1'b1;
                    g1_idx = scan_idx;
                end
            end
        end

        // No-wb requesters consume no port and are always accepted.
        req_ready = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_ready[i] = req_valid[i] & (~req_need_to_wb[i]
                         | (grant0 && (g0_idx == 2'(i)))
                         | (grant1 && (g1_idx == 2'(i))));
        end
        if (flush_valid) begin
            req_ready = '0;
        end
    end

    always_comb begin
        wb0_valid_d = 1'b0;
        wb1_valid_d = 1'b0;
        wb0_prd_d   = wb0_prd_q;
        wb1_prd_d   = wb1_prd_q;
        wb0_data_d  = wb0_data_q;
        wb1_data_d  = wb1_data_q;
        rr_ptr_d    = rr_ptr_q;

        if (flush_valid) begin
            rr_ptr_d = 2'd0;
        end else begin
            if (grant0) begin
                wb0_valid_d = 1'b1;
                wb0_prd_d   = req_prd[g0_idx*PREG_W +: PREG_W];
                wb0_data_d  = req_data[g0_idx*DATA_W +: DATA_W];
                rr_ptr_d    = g0_idx + 2'd1;
            end
            if (grant1) begin
                wb1_valid_d = 1'b1;
                wb1_prd_d   = req_prd[g1_idx*PREG_W +: PREG_W];
                wb1_data_d  = req_data[g1_idx*DATA_W +: DATA_W];
                // Pointer moves past the last-granted requester.
                rr_ptr_d    = g1_idx + 2'd1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wb0_valid_q <= 1'b0;
            wb1_valid_q <= 1'b0;
            wb0_prd_q   <= '0;
            wb1_prd_q   <= '0;
            wb0_data_q  <= '0;
            wb1_data_q  <= '0;
            rr_ptr_q    <= 2'd0;
        end else begin
            wb0_valid_q <= wb0_valid_d;
            wb1_valid_q <= wb1_valid_d;
            wb0_prd_q   <= wb0_prd_d;
            wb1_prd_q   <= wb1_prd_d;
            wb0_data_q  <= wb0_data_d;
            wb1_data_q  <= wb1_data_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign wb0_valid = wb0_valid_q;
    assign wb0_prd   = wb0_prd_q;
    assign wb0_data  = wb0_data_q;
    assign wb1_valid = wb1_valid_q;
    assign wb1_prd   = wb1_prd_q;
    assign wb1_data  = wb1_data_q;
    assign rr_ptr_o  = rr_ptr_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: directed scenarios plus randomized traffic
// compared against a priority-rank reference model.
// Inputs change 1 time unit after the rising edge; outputs are sampled away from the edge.
module tb_wb_port_arbiter;

    localparam int PW = 6;
    localparam int DW = 64;

    logic            clock = 1'b0;
    logic            reset_n = 1'b0;
    logic            flush_valid = 1'b0;
    logic [3:0]      req_valid = '0;
    logic [3:0]      req_need_to_wb = '0;
    logic [4*PW-1:0] req_prd = '0;
    logic [4*DW-1:0] req_data = '0;
    logic [3:0]      req_ready;
    logic            wb0_valid, wb1_valid;
    logic [PW-1:0]   wb0_prd, wb1_prd;
    logic [DW-1:0]   wb0_data, wb1_data;
    logic [1:0]      rr_ptr_o;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int          m_ptr;
    logic        m_v0, m_v1;
    logic [PW-1:0] m_p0, m_p1;
    logic [DW-1:0] m_d0, m_d1;

    wb_port_arbiter #(.PREG_W(PW), .DATA_W(DW), .NREQ(4)) dut (
        .clock(clock), .reset_n(reset_n), .flush_valid(flush_valid),
        .req_valid(req_valid), .req_need_to_wb(req_need_to_wb),
        .req_prd(req_prd), .req_data(req_data), .req_ready(req_ready),
        .wb0_valid(wb0_valid), .wb0_prd(wb0_prd), .wb0_data(wb0_data),
        .wb1_valid(wb1_valid), .wb1_prd(wb1_prd), .wb1_data(wb1_data),
        .rr_ptr_o(rr_ptr_o)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // A wb requester's priority is its cyclic distance from the pointer; it wins a
    // port when fewer than two other wb requesters are closer.
    function automatic void model_arb(input logic [3:0] v, input logic [3:0] n, input logic fl,
                                      input int ptr, output logic [3:0] rdy,
                                      output int ng, output int g0, output int g1);
        rdy = '0; ng = 0; g0 = 0; g1 = 0;
        for (int i = 0; i < 4; i++) begin
            if (v[i] && !n[i]) rdy[i] = 1'b1;
            if (v[i] && n[i]) begin
                int rank = 0;
                int di = (i - ptr + 4) % 4;
                for (int j = 0; j < 4; j++)
                    if (v[j] && n[j] && ((j - ptr + 4) % 4) < di) rank++;
                if (rank < 2) begin
                    rdy[i] = 1'b1;
                    ng++;
                    if (rank == 0) g0 = i; else g1 = i;
                end
            end
        end
        if (fl) begin
            rdy = '0; ng = 0;
        end
    endfunction

    task automatic model_reset();
        m_ptr = 0; m_v0 = 0; m_v1 = 0; m_p0 = '0; m_p1 = '0; m_d0 = '0; m_d1 = '0;
    endtask

    // Advance one clock, updating the model from the inputs present before the edge.
    task automatic tick();
        logic [3:0] r; int ng, g0, g1;
        model_arb(req_valid, req_need_to_wb, flush_valid, m_ptr, r, ng, g0, g1);
        @(posedge clock);
        if (flush_valid) begin
            m_v0 = 0; m_v1 = 0; m_ptr = 0;
        end else begin
            m_v0 = (ng >= 1);
            m_v1 = (ng >= 2);
            if (ng >= 1) begin m_p0 = req_prd[g0*PW +: PW]; m_d0 = req_data[g0*DW +: DW]; end
            if (ng >= 2) begin m_p1 = req_prd[g1*PW +: PW]; m_d1 = req_data[g1*DW +: DW]; end
            if (ng == 2) m_ptr = (g1 + 1) % 4;
            else if (ng == 1) m_ptr = (g0 + 1) % 4;
        end
        #1;
    endtask

    task automatic randomize_payload();
        for (int i = 0; i < 4; i++) begin
            req_prd[i*PW +: PW]  = PW'($urandom);
            req_data[i*DW +: DW] = {$urandom, $urandom};
        end
    endtask

    task automatic test_reset();
        reset_n = 0; req_valid = '0; req_need_to_wb = '0; flush_valid = 0;
        model_reset();
        repeat (3) @(posedge clock);
        #2;
        checks++;
        if (wb0_valid !== 1'b0 || wb1_valid !== 1'b0) begin
            errors++; $display("FAIL reset_valid: got %b/%b want 0/0", wb0_valid, wb1_valid);
        end
        checks++;
        if (wb0_prd !== '0 || wb1_prd !== '0 || wb0_data !== '0 || wb1_data !== '0) begin
            errors++; $display("FAIL reset_payload: prd %0d/%0d data %h/%h want zeros", wb0_prd, wb1_prd, wb0_data, wb1_data);
        end
        checks++;
        if (rr_ptr_o !== 2'd0 || req_ready !== 4'b0000) begin
            errors++; $display("FAIL reset_ptr_ready: ptr %0d ready %b want 0 0000", rr_ptr_o, req_ready);
        end
        reset_n = 1;
        tick();
    endtask

    task automatic test_single();
        randomize_payload();
        req_valid = 4'b0100; req_need_to_wb = 4'b0100;
        req_prd[2*PW +: PW] = 6'd17; req_data[2*DW +: DW] = 64'hDEAD;
        #2;
        checks++;
        if (req_ready !== 4'b0100) begin
            errors++; $display("FAIL single_ready: got %b want 0100", req_ready);
        end
        tick();
        req_valid = '0;
        checks++;
        if (wb0_valid !== 1'b1 || wb0_prd !== 6'd17 || wb0_data !== 64'hDEAD || wb1_valid !== 1'b0) begin
            errors++; $display("FAIL single_wb: v0 %b prd %0d data %h v1 %b want 1 17 dead 0", wb0_valid, wb0_prd, wb0_data, wb1_valid);
        end
        checks++;
        if (rr_ptr_o !== 2'd3) begin
            errors++; $display("FAIL single_ptr: got %0d want 3", rr_ptr_o);
        end
    endtask

    task automatic test_contention();
        logic [4*PW-1:0] p; logic [4*DW-1:0] d;
        flush_valid = 1; tick(); flush_valid = 0;   // pointer back to 0
        randomize_payload();
        p = req_prd; d = req_data;
        req_valid = 4'b1111; req_need_to_wb = 4'b1111;
        #2;
        checks++;
        if (req_ready !== 4'b0011) begin
            errors++; $display("FAIL cont1_ready: got %b want 0011", req_ready);
        end
        tick();
        checks++;
        if (wb0_valid !== 1 || wb1_valid !== 1 || wb0_prd !== p[0 +: PW] || wb1_prd !== p[PW +: PW]
            || wb0_data !== d[0 +: DW] || wb1_data !== d[DW +: DW] || rr_ptr_o !== 2'd2) begin
            errors++; $display("FAIL cont1_wb: prd %0d/%0d ptr %0d want %0d/%0d ptr 2", wb0_prd, wb1_prd, rr_ptr_o, p[0 +: PW], p[PW +: PW]);
        end
        checks++;
        if (req_ready !== 4'b1100) begin
            errors++; $display("FAIL cont2_ready: got %b want 1100", req_ready);
        end
        tick();
        req_valid = '0;
        checks++;
        if (wb0_valid !== 1 || wb1_valid !== 1 || wb0_prd !== p[2*PW +: PW] || wb1_prd !== p[3*PW +: PW]
            || wb0_data !== d[2*DW +: DW] || wb1_data !== d[3*DW +: DW] || rr_ptr_o !== 2'd0) begin
            errors++; $display("FAIL cont2_wb: prd %0d/%0d ptr %0d want %0d/%0d ptr 0", wb0_prd, wb1_prd, rr_ptr_o, p[2*PW +: PW], p[3*PW +: PW]);
        end
    endtask

    task automatic test_wrap_nowb();
        logic [4*PW-1:0] p; logic [4*DW-1:0] d;
        randomize_payload();
        req_valid = 4'b0100; req_need_to_wb = 4'b0100;   // grant req2 -> pointer 3
        tick();
        randomize_payload();
        p = req_prd; d = req_data;
        req_valid = 4'b1011; req_need_to_wb = 4'b1001;
        #2;
        checks++;
        if (rr_ptr_o !== 2'd3 || req_ready !== 4'b1011) begin
            errors++; $display("FAIL wrap_ready: ptr %0d ready %b want 3 1011", rr_ptr_o, req_ready);
        end
        tick();
        req_valid = '0;
        checks++;
        if (wb0_valid !== 1 || wb1_valid !== 1 || wb0_prd !== p[3*PW +: PW] || wb1_prd !== p[0 +: PW]
            || wb0_data !== d[3*DW +: DW] || wb1_data !== d[0 +: DW] || rr_ptr_o !== 2'd1) begin
            errors++; $display("FAIL wrap_wb: prd %0d/%0d ptr %0d want %0d/%0d ptr 1", wb0_prd, wb1_prd, rr_ptr_o, p[3*PW +: PW], p[0 +: PW]);
        end
    endtask

    task automatic test_flush();
        logic [PW-1:0] hp0;
        randomize_payload();
        req_valid = 4'b0110; req_need_to_wb = 4'b0110;
        tick();                                  // ports busy entering the flush cycle
        hp0 = m_p0;
        randomize_payload();
        req_valid = 4'b1111; req_need_to_wb = 4'b1111; flush_valid = 1;
        #2;
        checks++;
        if (req_ready !== 4'b0000) begin
            errors++; $display("FAIL flush_ready: got %b want 0000", req_ready);
        end
        checks++;
        if (wb0_valid !== 1'b1) begin
            errors++; $display("FAIL flush_older_write: wb0_valid %b want 1", wb0_valid);
        end
        tick();
        flush_valid = 0; req_valid = '0;
        checks++;
        if (wb0_valid !== 0 || wb1_valid !== 0 || rr_ptr_o !== 2'd0 || wb0_prd !== hp0) begin
            errors++; $display("FAIL flush_after: v %b/%b ptr %0d prd %0d want 0/0 0 %0d", wb0_valid, wb1_valid, rr_ptr_o, wb0_prd, hp0);
        end
    endtask

    task automatic test_async_reset();
        logic [4*PW-1:0] p;
        randomize_payload();
        req_valid = 4'b0010; req_need_to_wb = 4'b0010;
        tick();
        req_valid = '0;
        #2 reset_n = 0;
        #1;
        checks++;
        if (wb0_valid !== 0 || wb0_prd !== '0 || wb0_data !== '0 || rr_ptr_o !== 2'd0) begin
            errors++; $display("FAIL async_reset: v0 %b prd %0d ptr %0d want 0 0 0", wb0_valid, wb0_prd, rr_ptr_o);
        end
        model_reset();
        #2 reset_n = 1;
        randomize_payload();
        p = req_prd;
        req_valid = 4'b1111; req_need_to_wb = 4'b1111;
        #1;
        checks++;
        if (req_ready !== 4'b0011) begin
            errors++; $display("FAIL post_reset_ready: got %b want 0011", req_ready);
        end
        tick();
        req_valid = '0;
        checks++;
        if (wb0_valid !== 1 || wb0_prd !== p[0 +: PW]) begin
            errors++; $display("FAIL post_reset_wb0: v %b prd %0d want 1 %0d", wb0_valid, wb0_prd, p[0 +: PW]);
        end
    endtask

    task automatic test_random();
        logic [3:0] held = '0;
        int wait_cnt [4] = '{0, 0, 0, 0};
        logic [3:0] r; int ng, g0, g1;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 4; i++) begin
                if (!held[i]) begin
                    req_valid[i]         = 1'($urandom_range(0, 1));
                    req_need_to_wb[i]    = ($urandom_range(0, 2) != 0);
                    req_prd[i*PW +: PW]  = PW'($urandom);
                    req_data[i*DW +: DW] = {$urandom, $urandom};
                end
            end
            flush_valid = ($urandom_range(0, 9) == 0);
            #2;
            model_arb(req_valid, req_need_to_wb, flush_valid, m_ptr, r, ng, g0, g1);
            checks++;
            if (req_ready !== r) begin
                errors++; $display("FAIL rnd_ready cyc %0d: got %b want %b", c, req_ready, r);
            end
            for (int i = 0; i < 4; i++) begin
                if (req_valid[i] && req_need_to_wb[i] && !r[i] && !flush_valid) wait_cnt[i]++;
                else wait_cnt[i] = 0;
                held[i] = req_valid[i] && req_need_to_wb[i] && !r[i] && !flush_valid;
            end
            checks++;
            if (wait_cnt[0] > 1 || wait_cnt[1] > 1 || wait_cnt[2] > 1 || wait_cnt[3] > 1) begin
                errors++; $display("FAIL rnd_fairness cyc %0d: waits %0d %0d %0d %0d want <=1", c, wait_cnt[0], wait_cnt[1], wait_cnt[2], wait_cnt[3]);
            end
            tick();
            checks++;
            if (wb0_valid !== m_v0 || wb1_valid !== m_v1 || rr_ptr_o !== 2'(m_ptr)) begin
                errors++; $display("FAIL rnd_ctrl cyc %0d: v %b/%b ptr %0d want %b/%b ptr %0d", c, wb0_valid, wb1_valid, rr_ptr_o, m_v0, m_v1, m_ptr);
            end
            checks++;
            if (wb0_prd !== m_p0 || wb1_prd !== m_p1 || wb0_data !== m_d0 || wb1_data !== m_d1) begin
                errors++; $display("FAIL rnd_payload cyc %0d: prd %0d/%0d want %0d/%0d", c, wb0_prd, wb1_prd, m_p0, m_p1);
            end
            checks++;
            if (wb1_valid && !wb0_valid) begin
                errors++; $display("FAIL rnd_port1_alone cyc %0d: v0 %b v1 %b want v1 only with v0", c, wb0_valid, wb1_valid);
            end
        end
        req_valid = '0; flush_valid = 0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_wrap_nowb();
        test_flush();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
